// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: requester handshakes, register file write port,
// issue-stage scoreboard set and hazard query.
interface wb_arbiter_if #(
   parameter int REQ_NUM = 3,
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 5
);
   logic [REQ_NUM-1:0]        I_req_valid;
   logic [REQ_NUM*ADDR_W-1:0] I_req_addr;
   logic [REQ_NUM*DATA_W-1:0] I_req_data;
   logic [REQ_NUM-1:0]        O_req_ready;

   logic                      O_rd_we;
   logic [ADDR_W-1:0]         O_rd_waddr;
   logic [DATA_W-1:0]         O_rd_wdata;

   logic                      I_issue_valid;
   logic [ADDR_W-1:0]         I_issue_rd;
   logic                      I_issue_rd_en;
   logic [ADDR_W-1:0]         I_chk_rs1;
   logic [ADDR_W-1:0]         I_chk_rs2;
   logic [ADDR_W-1:0]         I_chk_rd;
   logic                      O_hazard;

   // Arbiter side
   modport slave (
      input  I_req_valid, I_req_addr, I_req_data,
      input  I_issue_valid, I_issue_rd, I_issue_rd_en,
      input  I_chk_rs1, I_chk_rs2, I_chk_rd,
      output O_req_ready, O_rd_we, O_rd_waddr, O_rd_wdata, O_hazard
   );

   // Execute units / issue stage / register file side
   modport master (
      output I_req_valid, I_req_addr, I_req_data,
      output I_issue_valid, I_issue_rd, I_issue_rd_en,
      output I_chk_rs1, I_chk_rs2, I_chk_rd,
      input  O_req_ready, O_rd_we, O_rd_waddr, O_rd_wdata, O_hazard
   );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter with one-entry output register and RAW/WAW scoreboard.
// Define WB_ARB_RR_EN for round-robin arbitration; default is fixed priority (index 0 highest).
module wb_arbiter #(
   parameter int REQ_NUM = 3,
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 5
) (
   input  logic         clk,
   input  logic         rst_n,
   wb_arbiter_if.slave  bus
);

   localparam int REG_NUM = 2 ** ADDR_W;
   localparam int PTR_W   = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

   logic [REQ_NUM-1:0] grant;
   logic [PTR_W-1:0]   grant_idx;
   logic               grant_found;
   logic               hs;
   logic [ADDR_W-1:0]  sel_addr;
   logic [DATA_W-1:0]  sel_data;

   logic               rd_we_q,    rd_we_d;
   logic [ADDR_W-1:0]  rd_waddr_q, rd_waddr_d;
   logic [DATA_W-1:0]  rd_wdata_q, rd_wdata_d;
   logic [REG_NUM-1:0] pending_q,  pending_d;

   logic               sb_set;
   logic               busy_rs1, busy_rs2, busy_rd;

`ifdef WB_ARB_RR_EN
   logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;

   // Search starts at the pointer and wraps, so the last winner is visited last.
   always_comb begin
      int idx;
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      grant       = '0;
      grant_idx   = '0;
      grant_found = 1'b0;
      idx         = 0;
      for (int k = 0; k < REQ_NUM; k++) begin
         idx = int'(rr_ptr_q) + k;
         if (idx >= REQ_NUM) idx = idx - REQ_NUM;
         if (!grant_found && bus.I_req_valid[idx]) begin
            grant[idx]  = 1'b1;
            grant_idx   = PTR_W'(idx);
            grant_found = 1'b1;
         end
      end
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (hs) begin
         rr_ptr_d = (int'(grant_idx) == REQ_NUM - 1) ? '0 : grant_idx + PTR_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
      end
   end
`else
   always_comb begin
      grant       = '0;
      grant_idx   = '0;
      grant_found = 1'b0;
      for (int k = 0; k < REQ_NUM; k++) begin
         if (!grant_found && bus.I_req_valid[k]) begin
            grant[k]    = 1'b1;
            grant_idx   = PTR_W'(k);
            grant_found = 1'b1;
         end
      end
   end
`endif

   // Ready is purely a function of the requests: the write port never stalls.
   assign bus.O_req_ready = grant;
   assign hs              = grant_found;
   assign sel_addr        = bus.I_req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
   assign sel_data        = bus.I_req_data[int'(grant_idx)*DATA_W +: DATA_W];

   // Writes to x0 complete the handshake but never reach the register file.
   always_comb begin
      rd_we_d    = hs && (sel_addr != '0);
      rd_waddr_d = rd_waddr_q;
      rd_wdata_d = rd_wdata_q;
      if (hs) begin
         rd_waddr_d = sel_addr;
         rd_wdata_d = sel_data;
      end
   end

   assign sb_set = bus.I_issue_valid && bus.I_issue_rd_en && (bus.I_issue_rd != '0);

   // Clear first, then set, so a register re-issued while its old value retires stays pending.
   always_comb begin
      pending_d = pending_q;
      if (rd_we_q) pending_d[rd_waddr_q] = 1'b0;
      if (sb_set)  pending_d[bus.I_issue_rd] = 1'b1;
      pending_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: the scoreboard is a flop vector, not a RAM, so clearing it in reset is cheap and required to drop stale stalls.
      if (!rst_n) begin
         rd_we_q    <= 1'b0;
         rd_waddr_q <= '0;
         rd_wdata_q <= '0;
         pending_q  <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         rd_we_q    <= rd_we_d;
         rd_waddr_q <= rd_waddr_d;
         rd_wdata_q <= rd_wdata_d;
         pending_q  <= pending_d;
      end
   end

   // A register retiring this cycle is bypassed by the register file, so it is not busy.
   function automatic logic reg_busy(input logic [REG_NUM-1:0] pend,
                                     input logic               we,
                                     input logic [ADDR_W-1:0]  waddr,
                                     input logic [ADDR_W-1:0]  r);
      return pend[r] && (r != '0) && !(we && (waddr == r));
   endfunction

   assign busy_rs1 = reg_busy(pending_q, rd_we_q, rd_waddr_q, bus.I_chk_rs1);
   assign busy_rs2 = reg_busy(pending_q, rd_we_q, rd_waddr_q, bus.I_chk_rs2);
   assign busy_rd  = reg_busy(pending_q, rd_we_q, rd_waddr_q, bus.I_chk_rd);

   assign bus.O_hazard   = busy_rs1 | busy_rs2 | busy_rd;
   assign bus.O_rd_we    = rd_we_q;
   assign bus.O_rd_waddr = rd_waddr_q;
   assign bus.O_rd_wdata = rd_wdata_q;

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter and register scoreboard for the 32-entry integer register file. It shares the register file's single write port among REQ_NUM writeback requesters, such as the ALU, the load unit and the multiply/divide unit, using a valid/ready handshake. It drives the write port from a one-entry output register. It also tracks in-flight destination registers so the issue stage can stall on RAW and WAW hazards. It sits between the execute-side units and the register file write port (rd_we / rd_waddr / rd_wdata).

## Interface
- REQ_NUM, 3: number of writeback requesters (2..8)
- DATA_W, 32: register data width
- ADDR_W, 5: register address width; scoreboard depth is 2**ADDR_W
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- I_req_valid  in  REQ_NUM  requester i holds a writeback
- I_req_addr  in  REQ_NUM*ADDR_W  destination of requester i, slice [i*ADDR_W +: ADDR_W]
- I_req_data  in  REQ_NUM*DATA_W  data of requester i, slice [i*DATA_W +: DATA_W]
- O_req_ready  out  REQ_NUM  one-hot grant; handshake completes on valid & ready at the clock edge
- O_rd_we  out  1  register file write enable
- O_rd_waddr  out  ADDR_W  register file write address
- O_rd_wdata  out  DATA_W  register file write data
- I_issue_valid  in  1  issue stage dispatches an instruction this cycle
- I_issue_rd  in  ADDR_W  destination of the dispatched instruction
- I_issue_rd_en  in  1  dispatched instruction writes a register
- I_chk_rs1  in  ADDR_W  source 1 of the instruction being considered for issue
- I_chk_rs2  in  ADDR_W  source 2 of the instruction being considered for issue
- I_chk_rd  in  ADDR_W  destination of the instruction being considered for issue
- O_hazard  out  1  issue stage must stall this cycle

## Operation
- Arbitration (combinational):
  - Among asserted I_req_valid bits, select exactly one winner and assert its O_req_ready.
  - When no request is valid, O_req_ready = 0.
  - O_req_ready never depends on the output register: the write port never back-pressures.
- Requester rule: once valid is asserted, addr and data are held stable until the handshake completes.
- Output register: on a completed handshake, capture {we = (addr != 0), addr, data}; with no handshake, we <= 0.
  - addr and data hold their last values when we = 0.
- Writes to x0: the handshake completes normally, the write is dropped (O_rd_we = 0) and no scoreboard bit is touched.
- Scoreboard: pending[0:2**ADDR_W-1]; pending[0] is constantly 0.
  - Set: I_issue_valid & I_issue_rd_en & (I_issue_rd != 0) sets pending[I_issue_rd] at the edge.
  - Clear: O_rd_we clears pending[O_rd_waddr] at the edge.
  - Same register set and cleared in the same cycle: set wins.
- Hazard: O_hazard = busy(I_chk_rs1) | busy(I_chk_rs2) | busy(I_chk_rd).
  - busy(r) = pending[r] & (r != 0) & !(O_rd_we & O_rd_waddr == r).
  - A register being written this cycle is not busy, because the register file bypasses the write data.
- WAW safety: busy(I_chk_rd) guarantees at most one in-flight producer per register.

## Timing
- Handshake at edge N -> O_rd_we/addr/data valid during cycle N+1 -> register file written at edge N+1.
- Scoreboard set at issue edge; O_hazard reflects it from the next cycle.
- Peak throughput: one write per cycle. A requester waits at most REQ_NUM-1 cycles with round-robin; it can be starved with fixed priority.
- Reset (asynchronous assert, synchronous-to-clk deassert assumed by the system):
  - O_rd_we = 0, O_rd_waddr = 0, O_rd_wdata = 0.
  - All pending bits = 0.
  - Round-robin pointer = 0.
  - O_req_ready follows the arbitration rule from inputs.
- Reset mid-operation: any in-flight write held in the output register is lost. The scoreboard clears, so no false stall remains.

## Configuration
- WB_ARB_RR_EN defined: round-robin arbitration.
  - Pointer p (0..REQ_NUM-1); search starts at p, wrapping.
  - On a completed handshake by requester g, p <= (g+1) mod REQ_NUM.
  - With no handshake, p holds.
- WB_ARB_RR_EN undefined: fixed priority, index 0 highest. No pointer state exists.

## Test plan
- Reset: drive rst_n = 0 mid-traffic -> O_rd_we = 0, O_rd_waddr = 0, O_rd_wdata = 0, O_hazard = 0 for any I_chk_*, all immediately.
- Single request: req0 valid, addr 5, data 0xDEADBEEF at edge N -> O_req_ready = 001 in cycle N, then O_rd_we = 1, O_rd_waddr = 5, O_rd_wdata = 0xDEADBEEF in cycle N+1 only.
- Contention, RR: all three valid continuously for 6 cycles -> grants 0, 1, 2, 0, 1, 2. Without WB_ARB_RR_EN -> grants 0, 0, 0, 0, 0, 0.
- x0 write: req1 valid, addr 0 -> handshake completes and O_rd_we stays 0 next cycle.
- Scoreboard: issue rd = 7, then I_chk_rs1 = 7 -> O_hazard = 1. During the cycle O_rd_we = 1 with O_rd_waddr = 7 -> O_hazard = 0, and pending[7] is clear afterwards.
- Simultaneous set/clear: issue rd = 9 in the same cycle O_rd_waddr = 9 writes -> pending[9] remains 1 and I_chk_rd = 9 gives O_hazard = 1 next cycle.
